// File: rtl/dtc_cmd_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : dtc_cmd_arb_pkg
//  Brief   : State encoding and shared constants for the DTC command arbiter.
//  Rev     : 1.0  initial release
// ============================================================================
package dtc_cmd_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_TOUT  = 3'd4
    } state_t;

    // Read data returned to the requester when the bus never answers
    localparam logic [19:0] TIMEOUT_DATA = 20'hFFFFF;

    localparam logic SEL_FEE   = 1'b1;
    localparam logic SEL_ALTRO = 1'b0;

endpackage
`default_nettype wire

// File: rtl/dtc_cmd_arb_if.sv
`default_nettype none
// ============================================================================
//  Module  : dtc_cmd_arb_if
//  Brief   : DTC command, local request and FEE register bus signal bundle.
//  Rev     : 1.0  initial release
// ============================================================================
interface dtc_cmd_arb_if #(
    parameter int AW = 20,
    parameter int DW = 20
);
    logic          dtc_cmd_exec;
    logic          dtc_cmd_rnw;
    logic          dtc_cmd_feenal;
    logic [AW-1:0] dtc_cmd_addr;
    logic [DW-1:0] dtc_cmd_data;
    logic          dtc_cmd_rst;
    logic          dtc_cmd_ack;
    logic [DW-1:0] dtc_rd_data;

    logic          loc_req;
    logic          loc_rnw;
    logic [AW-1:0] loc_addr;
    logic [DW-1:0] loc_wdata;
    logic          loc_ack;
    logic [DW-1:0] loc_rdata;

    logic          bus_req;
    logic          bus_rnw;
    logic          bus_sel;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata;
    logic          bus_ack;
    logic          bus_err;

    // Environment side: command sources and the register bus slave
    modport master (
        output dtc_cmd_exec, dtc_cmd_rnw, dtc_cmd_feenal, dtc_cmd_addr, dtc_cmd_data, dtc_cmd_rst,
        input  dtc_cmd_ack, dtc_rd_data,
        output loc_req, loc_rnw, loc_addr, loc_wdata,
        input  loc_ack, loc_rdata,
        input  bus_req, bus_rnw, bus_sel, bus_addr, bus_wdata, bus_err,
        output bus_rdata, bus_ack
    );

    // Arbiter side
    modport slave (
        input  dtc_cmd_exec, dtc_cmd_rnw, dtc_cmd_feenal, dtc_cmd_addr, dtc_cmd_data, dtc_cmd_rst,
        output dtc_cmd_ack, dtc_rd_data,
        input  loc_req, loc_rnw, loc_addr, loc_wdata,
        output loc_ack, loc_rdata,
        output bus_req, bus_rnw, bus_sel, bus_addr, bus_wdata, bus_err,
        input  bus_rdata, bus_ack
    );
endinterface
`default_nettype wire

// File: rtl/dtc_cmd_arb.sv
`default_nettype none
// ============================================================================
//  Module  : dtc_cmd_arb
//  Brief   : Round-robin arbiter executing DTC and local register commands on
//            the shared FEE bus, with bus timeout and DTC abort.
//  Rev     : 1.0  initial release
// ============================================================================
module dtc_cmd_arb
    import dtc_cmd_arb_pkg::*;
#(
    parameter int AW      = 20,
    parameter int DW      = 20,
    parameter int TIMEOUT = 200
) (
    input  wire logic         clkin,
    input  wire logic         reset_n,
    dtc_cmd_arb_if.slave      cmd_if
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t         r_state;
    logic           r_exec_q;
    logic           r_loc_q;
    logic           r_dtc_pend;
    logic           r_loc_pend;
    logic           r_rr_loc;
    logic           r_gnt_loc;
    logic [CNT_W-1:0] r_cnt;

    logic           r_bus_req;
    logic           r_bus_rnw;
    logic           r_bus_sel;
    logic [AW-1:0]  r_bus_addr;
    logic [DW-1:0]  r_bus_wdata;
    logic           r_bus_err;
    logic           r_dtc_ack;
    logic [DW-1:0]  r_dtc_rd_data;
    logic           r_loc_ack;
    logic [DW-1:0]  r_loc_rdata;

    logic           w_dtc_rise;
    logic           w_loc_rise;

    // Both requesters are edge-triggered so a level held past its ack never re-fires
    assign w_dtc_rise = cmd_if.dtc_cmd_exec & ~r_exec_q;
    assign w_loc_rise = cmd_if.loc_req & ~r_loc_q;

    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_exec_q      <= 1'b0;
            r_loc_q       <= 1'b0;
            r_dtc_pend    <= 1'b0;
            r_loc_pend    <= 1'b0;
            r_rr_loc      <= 1'b0;
            r_gnt_loc     <= 1'b0;
            r_cnt         <= '0;
            r_bus_req     <= 1'b0;
            r_bus_rnw     <= 1'b0;
            r_bus_sel     <= 1'b0;
            r_bus_addr    <= '0;
            r_bus_wdata   <= '0;
            r_bus_err     <= 1'b0;
            r_dtc_ack     <= 1'b0;
            r_dtc_rd_data <= '0;
            r_loc_ack     <= 1'b0;
            r_loc_rdata   <= '0;
        end else begin
            r_exec_q  <= cmd_if.dtc_cmd_exec;
            r_loc_q   <= cmd_if.loc_req;
            r_dtc_ack <= 1'b0;
            r_loc_ack <= 1'b0;

            if (w_dtc_rise && !r_dtc_pend) begin
                r_dtc_pend <= 1'b1;
            end
            if (w_loc_rise && !r_loc_pend) begin
                r_loc_pend <= 1'b1;
            end

            if (cmd_if.dtc_cmd_rst) begin
                // Abort drops any in-flight transfer; a pending local request is re-arbitrated
                r_state    <= ST_IDLE;
                r_bus_req  <= 1'b0;
                r_dtc_pend <= 1'b0;
                r_bus_err  <= 1'b0;
                r_cnt      <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (r_dtc_pend && r_loc_pend) begin
                            r_gnt_loc <= r_rr_loc;
                            r_rr_loc  <= ~r_rr_loc;
                            r_state   <= ST_GRANT;
                        end else if (r_dtc_pend || r_loc_pend) begin
                            r_gnt_loc <= r_loc_pend;
                            r_state   <= ST_GRANT;
                        end
                    end

                    ST_GRANT: begin
                        if (r_gnt_loc) begin
                            r_bus_rnw   <= cmd_if.loc_rnw;
                            r_bus_sel   <= SEL_FEE;
                            r_bus_addr  <= cmd_if.loc_addr;
                            r_bus_wdata <= cmd_if.loc_wdata;
                        end else begin
                            r_bus_rnw   <= cmd_if.dtc_cmd_rnw;
                            r_bus_sel   <= cmd_if.dtc_cmd_feenal ? SEL_FEE : SEL_ALTRO;
                            r_bus_addr  <= cmd_if.dtc_cmd_addr;
                            r_bus_wdata <= cmd_if.dtc_cmd_data;
                        end
                        r_bus_req <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= ST_WAIT;
                    end

                    ST_WAIT: begin
                        // An ack on the final cycle still counts as a normal completion
                        if (cmd_if.bus_ack) begin
                            r_bus_req <= 1'b0;
                            if (r_gnt_loc) begin
                                r_loc_ack   <= 1'b1;
                                r_loc_rdata <= r_bus_rnw ? cmd_if.bus_rdata : '0;
                            end else begin
                                r_dtc_ack     <= 1'b1;
                                r_dtc_rd_data <= r_bus_rnw ? cmd_if.bus_rdata : '0;
                            end
                            r_state <= ST_DONE;
                        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                            r_bus_req <= 1'b0;
                            r_bus_err <= 1'b1;
                            if (r_gnt_loc) begin
                                r_loc_ack   <= 1'b1;
                                r_loc_rdata <= DW'(TIMEOUT_DATA);
                            end else begin
                                r_dtc_ack     <= 1'b1;
                                r_dtc_rd_data <= DW'(TIMEOUT_DATA);
                            end
                            r_state <= ST_TOUT;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end

                    ST_DONE, ST_TOUT: begin
                        if (r_gnt_loc) begin
                            r_loc_pend <= 1'b0;
                        end else begin
                            r_dtc_pend <= 1'b0;
                        end
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end

                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign cmd_if.bus_req     = r_bus_req;
    assign cmd_if.bus_rnw     = r_bus_rnw;
    assign cmd_if.bus_sel     = r_bus_sel;
    assign cmd_if.bus_addr    = r_bus_addr;
    assign cmd_if.bus_wdata   = r_bus_wdata;
    assign cmd_if.bus_err     = r_bus_err;
    assign cmd_if.dtc_cmd_ack = r_dtc_ack;
    assign cmd_if.dtc_rd_data = r_dtc_rd_data;
    assign cmd_if.loc_ack     = r_loc_ack;
    assign cmd_if.loc_rdata   = r_loc_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dtc_cmd_arb.sv
`default_nettype none
// ============================================================================
//  Module  : tb_dtc_cmd_arb
//  Brief   : Scoreboard bench for dtc_cmd_arb with a bus responder and
//            transaction-level expectations.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_dtc_cmd_arb;

    localparam int TMO     = 200;
    localparam int K_NORM  = 0;
    localparam int K_TOUT  = 1;
    localparam int K_ABORT = 2;

    typedef struct {
        logic        rnw;
        logic        feenal;
        logic [19:0] addr;
        logic [19:0] data;
        int          kind;
        int          delay;
        logic [19:0] rdata;
    } req_t;

    typedef struct {
        logic        rnw;
        logic        sel;
        logic [19:0] addr;
        logic [19:0] wdata;
        int          kind;
        int          delay;
        logic [19:0] rdata;
    } bus_t;

    logic clkin = 1'b0;
    logic reset_n = 1'b0;
    always #5 clkin = ~clkin;

    dtc_cmd_arb_if #(.AW(20), .DW(20)) ifc ();

    dtc_cmd_arb #(.AW(20), .DW(20), .TIMEOUT(TMO)) dut (
        .clkin  (clkin),
        .reset_n(reset_n),
        .cmd_if (ifc)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    bus_t        q_bus[$];
    logic [19:0] q_dtc[$];
    logic [19:0] q_loc[$];
    bit          tie_loc = 1'b0;   // contention winner alternates, DTC first after reset

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input bit is_loc, input req_t r);
        bus_t        b;
        logic [19:0] a;
        b.rnw   = r.rnw;
        b.sel   = is_loc ? 1'b1 : r.feenal;
        b.addr  = r.addr;
        b.wdata = r.data;
        b.kind  = r.kind;
        b.delay = r.delay;
        b.rdata = r.rdata;
        q_bus.push_back(b);
        a = (r.kind == K_TOUT) ? 20'hFFFFF : (r.rnw ? r.rdata : 20'h0);
        if (r.kind != K_ABORT) begin
            if (is_loc) q_loc.push_back(a);
            else        q_dtc.push_back(a);
        end
    endtask

    task automatic drive_dtc(input req_t r);
        ifc.dtc_cmd_rnw    = r.rnw;
        ifc.dtc_cmd_feenal = r.feenal;
        ifc.dtc_cmd_addr   = r.addr;
        ifc.dtc_cmd_data   = r.data;
        ifc.dtc_cmd_exec   = 1'b1;
    endtask

    task automatic drive_loc(input req_t r);
        ifc.loc_rnw   = r.rnw;
        ifc.loc_addr  = r.addr;
        ifc.loc_wdata = r.data;
        ifc.loc_req   = 1'b1;
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.rnw    = 1'($urandom);
        r.feenal = 1'($urandom);
        r.addr   = 20'($urandom);
        r.data   = 20'($urandom);
        r.kind   = K_NORM;
        r.delay  = int'($urandom_range(1, 8));
        r.rdata  = 20'($urandom);
        return r;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while ((q_bus.size() != 0 || q_dtc.size() != 0 || q_loc.size() != 0) && n < 3000) begin
            @(negedge clkin);
            n++;
        end
        chk("round_complete", 32'(q_bus.size() + q_dtc.size() + q_loc.size()), 32'd0);
    endtask

    task automatic wait_bus_req();
        int n = 0;
        while (!ifc.bus_req && n < 50) begin
            @(negedge clkin);
            n++;
        end
        chk("bus_req_seen", 32'(ifc.bus_req), 32'd1);
    endtask

    task automatic run_round(input bit has_d, input req_t d, input bit has_l, input req_t l,
                             input int hold, input bit chk_lat);
        int n;
        if (has_d && has_l) begin
            if (tie_loc) begin push_exp(1, l); push_exp(0, d); end
            else         begin push_exp(0, d); push_exp(1, l); end
            tie_loc = !tie_loc;
        end else if (has_d) begin
            push_exp(0, d);
        end else begin
            push_exp(1, l);
        end
        @(negedge clkin);
        if (has_d) drive_dtc(d);
        if (has_l) drive_loc(l);
        if (chk_lat) begin
            n = 0;
            do begin
                @(negedge clkin);
                n++;
            end while (!ifc.bus_req && n < 10);
            chk("req_latency", 32'(n), 32'd3);
        end
        wait_idle();
        repeat (hold) @(negedge clkin);
        ifc.dtc_cmd_exec = 1'b0;
        ifc.loc_req      = 1'b0;
        repeat (2) @(negedge clkin);
    endtask

    // Bus responder: checks each transfer against the expected order and answers per its plan
    initial begin
        bus_t b;
        int   n;
        ifc.bus_ack   = 1'b0;
        ifc.bus_rdata = '0;
        forever begin
            @(negedge clkin);
            if (reset_n && ifc.bus_req) begin
                if (q_bus.size() == 0) begin
                    chk("bus_req_unexpected", 32'd1, 32'd0);
                    n = 0;
                    while (ifc.bus_req && n < 1000) begin @(negedge clkin); n++; end
                end else begin
                    b = q_bus.pop_front();
                    chk("bus_rnw",   32'(ifc.bus_rnw),   32'(b.rnw));
                    chk("bus_sel",   32'(ifc.bus_sel),   32'(b.sel));
                    chk("bus_addr",  32'(ifc.bus_addr),  32'(b.addr));
                    chk("bus_wdata", 32'(ifc.bus_wdata), 32'(b.wdata));
                    if (b.kind == K_NORM) begin
                        repeat (b.delay - 1) @(negedge clkin);
                        ifc.bus_ack   = 1'b1;
                        ifc.bus_rdata = b.rdata;
                        @(negedge clkin);
                        ifc.bus_ack   = 1'b0;
                        ifc.bus_rdata = 20'($urandom);
                        chk("bus_req_dropped", 32'(ifc.bus_req), 32'd0);
                    end else if (b.kind == K_TOUT) begin
                        n = 1;
                        forever begin
                            @(negedge clkin);
                            if (!ifc.bus_req || n >= 1000) break;
                            n++;
                        end
                        chk("bus_req_cycles", 32'(n), 32'(TMO));
                    end else begin
                        n = 0;
                        while (ifc.bus_req && n < 1000) begin @(negedge clkin); n++; end
                    end
                end
            end
        end
    end

    // Ack monitor
    logic [19:0] e_d, e_l;
    always @(negedge clkin) begin
        if (reset_n) begin
            if (ifc.dtc_cmd_ack) begin
                if (q_dtc.size() == 0) chk("dtc_ack_unexpected", 32'd1, 32'd0);
                else begin
                    e_d = q_dtc.pop_front();
                    chk("dtc_rd_data", 32'(ifc.dtc_rd_data), 32'(e_d));
                end
            end
            if (ifc.loc_ack) begin
                if (q_loc.size() == 0) chk("loc_ack_unexpected", 32'd1, 32'd0);
                else begin
                    e_l = q_loc.pop_front();
                    chk("loc_rdata", 32'(ifc.loc_rdata), 32'(e_l));
                end
            end
        end
    end

    initial begin
        req_t d, l;
        bit   hd, hl;
        ifc.dtc_cmd_exec = 1'b0; ifc.dtc_cmd_rnw = 1'b0; ifc.dtc_cmd_feenal = 1'b0;
        ifc.dtc_cmd_addr = '0;   ifc.dtc_cmd_data = '0;  ifc.dtc_cmd_rst = 1'b0;
        ifc.loc_req = 1'b0; ifc.loc_rnw = 1'b0; ifc.loc_addr = '0; ifc.loc_wdata = '0;

        repeat (3) @(negedge clkin);
        chk("rst_bus_req", 32'(ifc.bus_req), 32'd0);
        chk("rst_bus_err", 32'(ifc.bus_err), 32'd0);
        chk("rst_dtc_ack", 32'(ifc.dtc_cmd_ack), 32'd0);
        chk("rst_loc_ack", 32'(ifc.loc_ack), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clkin);

        // DTC write, ack on third wait cycle
        d = '{rnw: 1'b0, feenal: 1'b1, addr: 20'h00010, data: 20'h12345,
              kind: K_NORM, delay: 3, rdata: 20'h55555};
        run_round(1, d, 0, d, 0, 1);

        // DTC read, exec held long after ack
        d = '{rnw: 1'b1, feenal: 1'b0, addr: 20'h00123, data: 20'h0,
              kind: K_NORM, delay: 2, rdata: 20'hABCDE};
        run_round(1, d, 0, d, 10, 0);
        chk("dtc_rd_data_hold", 32'(ifc.dtc_rd_data), 32'h000ABCDE);

        // Simultaneous requests twice: DTC,local then local,DTC
        repeat (2) begin
            d = rand_req(); l = rand_req();
            run_round(1, d, 1, l, 1, 0);
        end

        // Timeout then sticky error
        d = rand_req(); d.kind = K_TOUT;
        run_round(1, d, 0, d, 0, 0);
        chk("bus_err_set", 32'(ifc.bus_err), 32'd1);
        l = rand_req();
        run_round(0, l, 1, l, 0, 0);
        chk("bus_err_sticky", 32'(ifc.bus_err), 32'd1);

        // DTC abort in WAIT with local pending
        d = rand_req(); d.kind = K_ABORT;
        push_exp(0, d);
        @(negedge clkin);
        drive_dtc(d);
        wait_bus_req();
        repeat (2) @(negedge clkin);
        l = rand_req(); l.rnw = 1'b1;
        push_exp(1, l);
        drive_loc(l);
        repeat (2) @(negedge clkin);
        ifc.dtc_cmd_rst  = 1'b1;
        ifc.dtc_cmd_exec = 1'b0;
        @(negedge clkin);
        ifc.dtc_cmd_rst = 1'b0;
        chk("abort_bus_req", 32'(ifc.bus_req), 32'd0);
        chk("abort_bus_err", 32'(ifc.bus_err), 32'd0);
        wait_idle();
        ifc.loc_req = 1'b0;
        repeat (2) @(negedge clkin);

        // Asynchronous reset mid-WAIT
        d = rand_req(); d.kind = K_ABORT;
        push_exp(0, d);
        @(negedge clkin);
        drive_dtc(d);
        wait_bus_req();
        repeat (2) @(negedge clkin);
        #2 reset_n = 1'b0;
        #1;
        chk("areset_bus_req", 32'(ifc.bus_req), 32'd0);
        chk("areset_dtc_ack", 32'(ifc.dtc_cmd_ack), 32'd0);
        chk("areset_rd_data", 32'(ifc.dtc_rd_data), 32'd0);
        chk("areset_bus_addr", 32'(ifc.bus_addr), 32'd0);
        ifc.dtc_cmd_exec = 1'b0;
        tie_loc = 1'b0;
        @(negedge clkin);
        reset_n = 1'b1;
        repeat (2) @(negedge clkin);
        d = rand_req();
        run_round(1, d, 0, d, 0, 1);

        // Randomized mix
        for (int i = 0; i < 30; i++) begin
            hd = 1'($urandom);
            hl = hd ? 1'($urandom) : 1'b1;
            d = rand_req(); l = rand_req();
            run_round(hd, d, hl, l, int'($urandom_range(0, 5)), 0);
        end
        chk("final_bus_err", 32'(ifc.bus_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
